// File: rtl/ranged_bit_write_sched.sv
// ============================================================================
// Module   : ranged_bit_write_sched
// Purpose  : Round-robin shared single-bit writes into a [LEFT:RIGHT] vector,
//            with range checking and a one-bit-per-cycle fill sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ranged_bit_write_sched #(
    parameter int  LEFT  = 8,
    parameter int  RIGHT = 1,
    parameter int  IDXW  = 8,
    parameter int  NREQ  = 2,
    localparam int W     = (LEFT > RIGHT) ? (LEFT - RIGHT + 1) : (RIGHT - LEFT + 1),
    localparam int LO    = (LEFT < RIGHT) ? LEFT : RIGHT,
    localparam int CW    = (W > 1) ? $clog2(W) : 1,
    localparam int NW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*IDXW-1:0] req_idx,
    input  logic [NREQ-1:0]      req_bit,
    input  logic                 sweep_start,
    input  logic                 sweep_fill,
    output logic [W-1:0]         vec,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NW-1:0]        err_id
);

    localparam logic [IDXW-1:0] c_lo_idx = IDXW'(LO);
    localparam logic [IDXW-1:0] c_hi_idx = IDXW'(LO + W - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [W-1:0]       r_vec;
    logic [NW-1:0]      r_rr;
    logic [CW-1:0]      r_cnt;
    logic               r_fill;
    logic               r_done;
    logic               r_err;
    logic [NW-1:0]      r_err_id;

    logic               w_hi_found;
    logic [NW-1:0]      w_hi_gnt;
    logic               w_lo_found;
    logic [NW-1:0]      w_lo_gnt;
    logic               w_found;
    logic [NW-1:0]      w_gnt;
    logic [IDXW-1:0]    w_sel_idx;
    logic               w_sel_bit;
    logic [NREQ-1:0]    w_ready;
    logic               w_xfer;
    logic               w_in_range;
    logic [CW-1:0]      w_off;
    logic [W-1:0]       w_wmask;
    logic [W-1:0]       w_smask;
    logic               w_last;
    logic [NW-1:0]      w_rr_next;

    // Round-robin: lowest valid at or above rr wins, else lowest valid below rr.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_gnt   = '0;
        w_lo_found = 1'b0;
        w_lo_gnt   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(r_rr)) begin
                    w_hi_found = 1'b1;
                    w_hi_gnt   = NW'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_gnt   = NW'(i);
                end
            end
        end
        w_found = w_hi_found | w_lo_found;
        w_gnt   = w_hi_found ? w_hi_gnt : w_lo_gnt;
    end

    always_comb begin
        w_sel_idx = '0;
        w_sel_bit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (NW'(i) == w_gnt) begin
                w_sel_idx = req_idx[i*IDXW +: IDXW];
                w_sel_bit = req_bit[i];
            end
        end
    end

    // FSM next state and grant outputs; a pending sweep start blocks all grants.
    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        case (r_state)
            ST_IDLE: begin
                if (sweep_start) begin
                    w_state_next = ST_SWEEP;
                end else if (w_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        w_ready[i] = (NW'(i) == w_gnt);
                    end
                end
            end
            ST_SWEEP: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_xfer     = |w_ready;
    assign w_in_range = (w_sel_idx >= c_lo_idx) && (w_sel_idx <= c_hi_idx);
    assign w_off      = CW'(w_sel_idx - c_lo_idx);
    assign w_wmask    = W'(1) << w_off;
    assign w_smask    = W'(1) << r_cnt;
    assign w_last     = (r_cnt == CW'(W - 1));
    assign w_rr_next  = (w_gnt == NW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec    <= '0;
            r_rr     <= '0;
            r_cnt    <= '0;
            r_fill   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_err_id <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (sweep_start) begin
                    r_fill <= sweep_fill;
                    r_cnt  <= '0;
                end else if (w_xfer) begin
                    if (w_in_range) begin
                        r_vec <= (r_vec & ~w_wmask) | (w_sel_bit ? w_wmask : '0);
                    end else begin
                        r_err    <= 1'b1;
                        r_err_id <= w_gnt;
                    end
                    r_rr <= w_rr_next;
                end
            end else begin
                r_vec <= (r_vec & ~w_smask) | (r_fill ? w_smask : '0);
                if (w_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign req_ready = w_ready;
    assign vec       = r_vec;
    assign busy      = (r_state == ST_SWEEP);
    assign done      = r_done;
    assign err       = r_err;
    assign err_id    = r_err_id;

endmodule

`default_nettype wire

// File: tb/tb_ranged_bit_write_sched.sv
// ============================================================================
// Module   : tb_ranged_bit_write_sched
// Purpose  : Directed checks of ranged_bit_write_sched for [8:1], [2:9], [5:5].
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ranged_bit_write_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: [8:1]
    logic       a_rst = 1'b1, a_start = 1'b0, a_fill = 1'b0;
    logic [1:0] a_valid = '0, a_bit = '0, a_ready;
    logic [15:0] a_idx = '0;
    logic [7:0] a_vec;
    logic       a_busy, a_done, a_err;
    logic [0:0] a_err_id;

    // DUT B: [2:9]
    logic       b_rst = 1'b1, b_start = 1'b0, b_fill = 1'b0;
    logic [1:0] b_valid = '0, b_bit = '0, b_ready;
    logic [15:0] b_idx = '0;
    logic [7:0] b_vec;
    logic       b_busy, b_done, b_err;
    logic [0:0] b_err_id;

    // DUT C: [5:5]
    logic       c_rst = 1'b1, c_start = 1'b0, c_fill = 1'b0;
    logic [1:0] c_valid = '0, c_bit = '0, c_ready;
    logic [15:0] c_idx = '0;
    logic [0:0] c_vec;
    logic       c_busy, c_done, c_err;
    logic [0:0] c_err_id;

    ranged_bit_write_sched #(.LEFT(8), .RIGHT(1), .IDXW(8), .NREQ(2)) u_a (
        .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_idx(a_idx), .req_bit(a_bit), .sweep_start(a_start), .sweep_fill(a_fill),
        .vec(a_vec), .busy(a_busy), .done(a_done), .err(a_err), .err_id(a_err_id)
    );

    ranged_bit_write_sched #(.LEFT(2), .RIGHT(9), .IDXW(8), .NREQ(2)) u_b (
        .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_idx(b_idx), .req_bit(b_bit), .sweep_start(b_start), .sweep_fill(b_fill),
        .vec(b_vec), .busy(b_busy), .done(b_done), .err(b_err), .err_id(b_err_id)
    );

    ranged_bit_write_sched #(.LEFT(5), .RIGHT(5), .IDXW(8), .NREQ(2)) u_c (
        .clk(clk), .rst(c_rst), .req_valid(c_valid), .req_ready(c_ready),
        .req_idx(c_idx), .req_bit(c_bit), .sweep_start(c_start), .sweep_fill(c_fill),
        .vec(c_vec), .busy(c_busy), .done(c_done), .err(c_err), .err_id(c_err_id)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a_reset();
        a_rst = 1'b1;
        #1;
        a_rst = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (a_vec !== 8'h00) begin n_fail++; $display("FAIL reset_vec got=%h exp=00", a_vec); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        n_checks++; if (a_done !== 1'b0 || a_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses done=%b err=%b exp=0/0", a_done, a_err); end
        n_checks++; if (a_err_id !== 1'b0) begin n_fail++; $display("FAIL reset_err_id got=%b exp=0", a_err_id); end
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        tick();
    endtask

    task automatic test_offset_desc();
        a_idx = {8'd0, 8'd1}; a_bit = 2'b01; a_valid = 2'b01;
        #1;
        n_checks++; if (a_ready !== 2'b01) begin n_fail++; $display("FAIL desc_ready got=%b exp=01", a_ready); end
        tick(); a_valid = 2'b00;
        n_checks++; if (a_vec !== 8'h01) begin n_fail++; $display("FAIL desc_idx1 got=%h exp=01", a_vec); end
        a_idx = {8'd0, 8'd8}; a_valid = 2'b01;
        tick(); a_valid = 2'b00;
        n_checks++; if (a_vec !== 8'h81) begin n_fail++; $display("FAIL desc_idx8 got=%h exp=81", a_vec); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL desc_no_err got=%b exp=0", a_err); end
    endtask

    task automatic test_ascending();
        b_bit = 2'b11;
        b_idx = {8'd0, 8'd2}; b_valid = 2'b01;
        tick(); b_valid = 2'b00;
        n_checks++; if (b_vec !== 8'h01) begin n_fail++; $display("FAIL asc_idx2 got=%h exp=01", b_vec); end
        b_idx = {8'd0, 8'd9}; b_valid = 2'b01;
        tick(); b_valid = 2'b00;
        n_checks++; if (b_vec !== 8'h81) begin n_fail++; $display("FAIL asc_idx9 got=%h exp=81", b_vec); end
        // Below and above the range on requester 0.
        b_idx = {8'd0, 8'd1}; b_valid = 2'b01;
        #1;
        n_checks++; if (b_ready !== 2'b01) begin n_fail++; $display("FAIL asc_oor_ready got=%b exp=01", b_ready); end
        tick(); b_valid = 2'b00;
        n_checks++; if (b_err !== 1'b1 || b_err_id !== 1'b0) begin n_fail++; $display("FAIL asc_idx1_err err=%b id=%b exp=1/0", b_err, b_err_id); end
        n_checks++; if (b_vec !== 8'h81) begin n_fail++; $display("FAIL asc_idx1_vec got=%h exp=81", b_vec); end
        tick();
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL asc_err_pulse got=%b exp=0", b_err); end
        b_idx = {8'd0, 8'd10}; b_valid = 2'b01;
        tick(); b_valid = 2'b00;
        n_checks++; if (b_err !== 1'b1 || b_err_id !== 1'b0 || b_vec !== 8'h81) begin n_fail++; $display("FAIL asc_idx10 err=%b id=%b vec=%h exp=1/0/81", b_err, b_err_id, b_vec); end
        tick();
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL asc_err_pulse2 got=%b exp=0", b_err); end
        // Requester 1: out-of-range then in-range (idx 5 -> offset 3).
        b_idx = {8'd0, 8'd0}; b_valid = 2'b10;
        tick(); b_valid = 2'b00;
        n_checks++; if (b_err !== 1'b1 || b_err_id !== 1'b1) begin n_fail++; $display("FAIL asc_req1_err err=%b id=%b exp=1/1", b_err, b_err_id); end
        b_idx = {8'd5, 8'd0}; b_valid = 2'b10;
        tick(); b_valid = 2'b00;
        n_checks++; if (b_vec !== 8'h89 || b_err !== 1'b0) begin n_fail++; $display("FAIL asc_req1_write vec=%h err=%b exp=89/0", b_vec, b_err); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        pulse_a_reset();
        a_idx = {8'd3, 8'd2}; a_bit = 2'b11; a_valid = 2'b11;
        exp_rdy = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (a_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_alt%0d got=%b exp=%b", k, a_ready, exp_rdy); end
            tick();
            exp_rdy = {exp_rdy[0], exp_rdy[1]};
        end
        a_valid = 2'b00;
        n_checks++; if (a_vec !== 8'h06) begin n_fail++; $display("FAIL rr_vec got=%h exp=06", a_vec); end
        a_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (a_ready !== 2'b10) begin n_fail++; $display("FAIL rr_single%0d got=%b exp=10", k, a_ready); end
            tick();
        end
        a_valid = 2'b00;
    endtask

    task automatic test_sweep();
        logic [7:0] ev;
        pulse_a_reset();
        a_idx = {8'd0, 8'd4}; a_bit = 2'b01; a_valid = 2'b01;
        a_fill = 1'b1; a_start = 1'b1;
        #1;
        n_checks++; if (a_ready !== 2'b00) begin n_fail++; $display("FAIL sweep_start_ready got=%b exp=00", a_ready); end
        tick(); a_start = 1'b0; a_fill = 1'b0;
        n_checks++; if (a_busy !== 1'b1 || a_vec !== 8'h00 || a_ready !== 2'b00) begin n_fail++; $display("FAIL sweep_enter busy=%b vec=%h rdy=%b exp=1/00/00", a_busy, a_vec, a_ready); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            ev = 8'((1 << k) - 1);
            n_checks++; if (a_vec !== ev) begin n_fail++; $display("FAIL sweep_vec%0d got=%h exp=%h", k, a_vec, ev); end
            n_checks++; if (a_busy !== (k < 8)) begin n_fail++; $display("FAIL sweep_busy%0d got=%b exp=%b", k, a_busy, (k < 8)); end
            n_checks++; if (a_done !== (k == 8)) begin n_fail++; $display("FAIL sweep_done%0d got=%b exp=%b", k, a_done, (k == 8)); end
            n_checks++; if (a_ready !== ((k == 8) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL sweep_ready%0d got=%b exp=%b", k, a_ready, ((k == 8) ? 2'b01 : 2'b00)); end
        end
        a_bit = 2'b00;
        tick(); a_valid = 2'b00;
        n_checks++; if (a_done !== 1'b0 || a_vec !== 8'hF7) begin n_fail++; $display("FAIL sweep_after done=%b vec=%h exp=0/f7", a_done, a_vec); end
    endtask

    task automatic test_mid_reset();
        logic saw_done;
        a_fill = 1'b1; a_start = 1'b1;
        tick(); a_start = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (a_vec !== 8'hF7 || a_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_progress vec=%h busy=%b exp=f7/1", a_vec, a_busy); end
        #2 a_rst = 1'b1;
        #1;
        n_checks++; if (a_vec !== 8'h00 || a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async vec=%h busy=%b exp=00/0", a_vec, a_busy); end
        tick(); a_rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (a_done !== 1'b0) saw_done = 1'b1;
            tick();
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", saw_done); end
        a_idx = {8'd0, 8'd4}; a_bit = 2'b01; a_valid = 2'b01;
        #1;
        n_checks++; if (a_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_grant got=%b exp=01", a_ready); end
        tick(); a_valid = 2'b00;
        n_checks++; if (a_vec !== 8'h08) begin n_fail++; $display("FAIL midrst_write got=%h exp=08", a_vec); end
    endtask

    task automatic test_boundary();
        c_bit = 2'b01;
        c_idx = {8'd0, 8'd5}; c_valid = 2'b01;
        tick(); c_valid = 2'b00;
        n_checks++; if (c_vec !== 1'b1 || c_err !== 1'b0) begin n_fail++; $display("FAIL w1_idx5 vec=%b err=%b exp=1/0", c_vec, c_err); end
        c_idx = {8'd0, 8'd4}; c_valid = 2'b01;
        tick();
        n_checks++; if (c_err !== 1'b1 || c_vec !== 1'b1) begin n_fail++; $display("FAIL w1_idx4 err=%b vec=%b exp=1/1", c_err, c_vec); end
        c_idx = {8'd0, 8'd6}; c_bit = 2'b00;
        tick(); c_valid = 2'b00;
        n_checks++; if (c_err !== 1'b1 || c_vec !== 1'b1) begin n_fail++; $display("FAIL w1_idx6 err=%b vec=%b exp=1/1", c_err, c_vec); end
        tick();
        n_checks++; if (c_err !== 1'b0) begin n_fail++; $display("FAIL w1_err_clear got=%b exp=0", c_err); end
        c_fill = 1'b0; c_start = 1'b1;
        tick(); c_start = 1'b0;
        n_checks++; if (c_busy !== 1'b1 || c_done !== 1'b0) begin n_fail++; $display("FAIL w1_sweep_busy busy=%b done=%b exp=1/0", c_busy, c_done); end
        tick();
        n_checks++; if (c_vec !== 1'b0 || c_busy !== 1'b0 || c_done !== 1'b1) begin n_fail++; $display("FAIL w1_sweep_end vec=%b busy=%b done=%b exp=0/0/1", c_vec, c_busy, c_done); end
        tick();
        n_checks++; if (c_done !== 1'b0) begin n_fail++; $display("FAIL w1_done_pulse got=%b exp=0", c_done); end
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        test_offset_desc();
        test_ascending();
        test_round_robin();
        test_sweep();
        test_mid_reset();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ranged_bit_write_sched.md
Name: ranged_bit_write_sched

Overview:
- Owns a single W-bit vector register declared with arbitrary SystemVerilog bounds [LEFT:RIGHT], ascending or descending.
- Shares single-bit write access to it among NREQ requesters through a round-robin arbiter.
- Translates each declared index into a physical bit offset and rejects out-of-range indices.
- A built-in sweep sequencer fills the whole vector one bit per cycle; test and bring-up logic uses it to initialise bit-addressed control vectors.

Parameters:
- LEFT, 8: left bound of the declared vector range; non-negative, < 2**IDXW.
- RIGHT, 1: right bound of the declared vector range; non-negative, < 2**IDXW.
- IDXW, 8: width of the unsigned request index.
- NREQ, 2: number of requesters; at least 1.
- Derived: W = |LEFT−RIGHT|+1; LO = min(LEFT,RIGHT); CW = clog2(W), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant/accept.
- req_idx  in  NREQ*IDXW  declared index; requester i occupies bits [i*IDXW +: IDXW].
- req_bit  in  NREQ  bit value to write.
- sweep_start  in  1  start a fill sweep.
- sweep_fill  in  1  fill value, latched at start.
- vec  out  W  register contents; physical bit 0 holds declared index LO.
- busy  out  1  high while in SWEEP.
- done  out  1  one-cycle pulse when a sweep completes.
- err  out  1  one-cycle pulse after an accepted out-of-range request.
- err_id  out  clog2(NREQ), min 1  requester that caused the last err.

Behaviour:
- Reset (async, immediate):
  - vec=0, state=IDLE, rr pointer=0, busy=0, done=0, err=0, err_id=0.
  - Reset asserted mid-sweep aborts the sweep; vec=0 regardless of progress.
- Index mapping:
  - Physical offset = req_idx − LO, for both range directions.
  - Example: [2:9] maps index 2 to offset 0 and index 9 to offset 7; [8:1] maps index 1 to offset 0 and index 8 to offset 7.
  - In range iff LO ≤ req_idx ≤ LO+W−1; compare unsigned at IDXW bits, with no wrap.
- States: IDLE, SWEEP.
- IDLE, arbitration:
  - Combinational grant goes to the first requester with valid set, scanning from rr upward modulo NREQ.
  - req_ready[g]=1 only for the granted requester; all other ready bits are 0.
  - If sweep_start=1 in the same cycle, all req_ready=0; the sweep wins.
  - At most one transfer (valid&&ready) per cycle.
- IDLE, transfer:
  - In range: vec[offset] is updated at that edge; all other bits are unchanged.
  - Out of range: the transfer still completes; vec is unchanged; err=1 for the next cycle and err_id=g.
  - In both cases rr becomes (g+1) mod NREQ.
  - With no transfer, rr holds.
- IDLE to SWEEP: when sweep_start=1 at an edge, latch the fill value, set cnt=0 and busy=1.
- SWEEP:
  - req_ready=0 for every requester; sweep_start is ignored.
  - Each edge writes vec[cnt]=fill and increments cnt.
  - On the edge that writes offset W−1: return to IDLE, busy=0, done=1 for one cycle.
  - Total: W write cycles; busy is high for exactly W cycles.
- err and done are registered pulses; they are 0 in every cycle not described above.
- Requester inputs may change freely while ready=0; requests are not queued internally.

Test Plan:
- Reset/offset, LEFT=8,RIGHT=1: req0 idx=1 bit=1 → vec=8'h01 next cycle. Then req0 idx=8 bit=1 → vec=8'h81; err stays 0.
- Ascending range, LEFT=2,RIGHT=9: idx=2 bit=1 → vec=8'h01; idx=9 bit=1 → vec=8'h81. idx=1 and idx=10 → handshake completes, vec unchanged, err pulses once each, err_id=0.
- Round-robin, NREQ=2: both valid continuously with different indices → grants alternate 0,1,0,1. A single requester valid alone is granted every cycle.
- Sweep: sweep_start with fill=1 and a concurrent req0 valid → ready0=0; vec fills 01,03,…,FF over 8 cycles; busy high 8 cycles; done pulses once. req0 is granted the cycle after done.
- Mid-sweep reset: assert rst after 3 sweep writes → vec=0, busy=0, done never pulses; a request after reset release is granted normally.
- Boundary, LEFT=RIGHT=5 (W=1): idx=5 writes vec[0]; idx=4 and idx=6 raise err. A sweep takes 1 cycle, with done on the following cycle.
